// File: rtl/hal_req_buffer.sv
// Posted-write FIFO plus single outstanding read between mem_controller and the host channel.
// Optional build macro RAW_FWD_EN: read hits on buffered writes are served from the FIFO.
module hal_req_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 36,
    parameter int unsigned DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    // Read side toward mem_controller
    input  logic              rd_go,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    // Write side toward mem_controller
    input  logic              wr_go,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    output logic              full,
    // Host read channel
    output logic              host_rd_req_valid,
    output logic [ADDR_W-1:0] host_rd_req_addr,
    input  logic              host_rd_req_ready,
    input  logic              host_rd_resp_valid,
    input  logic [DATA_W-1:0] host_rd_resp_data,
    // Host write channel
    output logic              host_wr_req_valid,
    output logic [ADDR_W-1:0] host_wr_req_addr,
    output logic [DATA_W-1:0] host_wr_req_data,
    input  logic              host_wr_req_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        R_IDLE,
        R_CHECK,
        R_ISSUE,
        R_WAIT,
        R_DONE
    } rd_state_e;

    // Write FIFO storage and bookkeeping
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0]  fifo_vld;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              wr_done_q;
    logic              push;
    logic              pop;

    // Read FSM state
    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              hazard;
`ifdef RAW_FWD_EN
    logic [DATA_W-1:0] fwd_data;
`endif

    assign full              = (count == (PW+1)'(DEPTH));
    assign host_wr_req_valid = (count != '0);
    assign host_wr_req_addr  = fifo_addr[rd_ptr];
    assign host_wr_req_data  = fifo_data[rd_ptr];
    assign wr_done           = wr_done_q;

    // wr_done_q masks the held request so one wr_go yields exactly one entry
    assign push = wr_go & ~full & ~wr_done_q;
    assign pop  = host_wr_req_valid & host_wr_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_vld  <= '0;
            wr_done_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            wr_done_q <= push;
            if (push) begin
                fifo_addr[wr_ptr] <= wr_addr;
                fifo_data[wr_ptr] <= wr_data;
                fifo_vld[wr_ptr]  <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to youngest so the last hit is the youngest matching write
    always_comb begin
        hazard = 1'b0;
`ifdef RAW_FWD_EN
        fwd_data = '0;
`endif
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (fifo_vld[rd_ptr + PW'(i)] && (fifo_addr[rd_ptr + PW'(i)] == rd_addr_q)) begin
                hazard = 1'b1;
`ifdef RAW_FWD_EN
                fwd_data = fifo_data[rd_ptr + PW'(i)];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= R_IDLE;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        case (state_q)
            R_IDLE: begin
                if (rd_go) begin
                    rd_addr_d = rd_addr;
                    state_d   = R_CHECK;
                end
            end
            R_CHECK: begin
                if (hazard) begin
`ifdef RAW_FWD_EN
                    rd_data_d = fwd_data;
                    state_d   = R_DONE;
`else
                    state_d   = R_CHECK;
`endif
                end else begin
                    state_d = R_ISSUE;
                end
            end
            R_ISSUE: begin
                if (host_rd_req_ready) state_d = R_WAIT;
            end
            R_WAIT: begin
                if (host_rd_resp_valid) begin
                    rd_data_d = host_rd_resp_data;
                    state_d   = R_DONE;
                end
            end
            R_DONE:  state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    assign empty             = (state_q == R_CHECK) || (state_q == R_ISSUE) || (state_q == R_WAIT);
    assign host_rd_req_valid = (state_q == R_ISSUE);
    assign host_rd_req_addr  = rd_addr_q;
    assign rd_done           = (state_q == R_DONE);
    assign rd_data           = rd_done ? rd_data_q : '0;

endmodule

// File: tb/tb_hal_req_buffer.sv
// Scoreboard bench for hal_req_buffer: directed stimulus, expectations queued, monitor compares.
module tb_hal_req_buffer;

    localparam int AW    = 36;
    localparam int DW    = 512;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_go;
    logic [AW-1:0] rd_addr;
    logic          rd_done;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          wr_go;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_done;
    logic          full;
    logic          host_rd_req_valid;
    logic [AW-1:0] host_rd_req_addr;
    logic          host_rd_req_ready;
    logic          host_rd_resp_valid;
    logic [DW-1:0] host_rd_resp_data;
    logic          host_wr_req_valid;
    logic [AW-1:0] host_wr_req_addr;
    logic [DW-1:0] host_wr_req_data;
    logic          host_wr_req_ready;

    hal_req_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rd_go              (rd_go),
        .rd_addr            (rd_addr),
        .rd_done            (rd_done),
        .rd_data            (rd_data),
        .empty              (empty),
        .wr_go              (wr_go),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .wr_done            (wr_done),
        .full               (full),
        .host_rd_req_valid  (host_rd_req_valid),
        .host_rd_req_addr   (host_rd_req_addr),
        .host_rd_req_ready  (host_rd_req_ready),
        .host_rd_resp_valid (host_rd_resp_valid),
        .host_rd_resp_data  (host_rd_resp_data),
        .host_wr_req_valid  (host_wr_req_valid),
        .host_wr_req_addr   (host_wr_req_addr),
        .host_wr_req_data   (host_wr_req_data),
        .host_wr_req_ready  (host_wr_req_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int occ      = 0;
    bit wr_phase_done;

    logic [AW-1:0] exp_wa [$];
    logic [DW-1:0] exp_wd [$];
    logic [AW-1:0] exp_ra [$];
    logic [DW-1:0] exp_rd [$];

    task automatic check(input bit ok, input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares host-visible transfers and read completions against queued expectations
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (rst) begin
            occ = 0;
        end else begin
            if (wr_done) occ++;
            check(full == (occ == DEPTH), "full vs occupancy", DW'(full), DW'(occ == DEPTH));
            check(occ <= DEPTH, "occupancy bound", DW'(occ), DW'(DEPTH));
            if (host_wr_req_valid && host_wr_req_ready) begin
                occ--;
                if (exp_wa.size() == 0) begin
                    check(1'b0, "unexpected host write", DW'(host_wr_req_addr), '0);
                end else begin
                    ea = exp_wa.pop_front();
                    ed = exp_wd.pop_front();
                    check(host_wr_req_addr == ea, "host wr addr", DW'(host_wr_req_addr), DW'(ea));
                    check(host_wr_req_data == ed, "host wr data", host_wr_req_data, ed);
                end
            end
            if (host_rd_req_valid && host_rd_req_ready) begin
                if (exp_ra.size() == 0) begin
                    check(1'b0, "unexpected host read", DW'(host_rd_req_addr), '0);
                end else begin
                    ea = exp_ra.pop_front();
                    check(host_rd_req_addr == ea, "host rd addr", DW'(host_rd_req_addr), DW'(ea));
                end
            end
            if (rd_done) begin
                if (exp_rd.size() == 0) begin
                    check(1'b0, "unexpected rd_done", rd_data, '0);
                end else begin
                    ed = exp_rd.pop_front();
                    check(rd_data == ed, "rd_data at rd_done", rd_data, ed);
                end
            end else begin
                check(rd_data == '0, "rd_data zero when idle", rd_data, '0);
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 1'b0;
        exp_wa.push_back(a);
        exp_wd.push_back(d);
        wr_go   = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (wr_done) begin
                ok = 1'b1;
                break;
            end
        end
        wr_go = 1'b0;
        check(ok, "wr_done within budget", DW'(ok), DW'(1));
    endtask

    task automatic wait_issue(output int cycles);
        bit ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            cycles++;
            if (!empty) break;
            if (host_rd_req_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(ok, "host read issued while empty held", DW'(ok), DW'(1));
    endtask

    task automatic complete_read(input logic [DW-1:0] d, input int delay, inout int cycles);
        tick();
        cycles++;
        for (int i = 0; i < delay; i++) begin
            check(empty && !rd_done, "empty while awaiting resp", DW'(empty), DW'(1));
            tick();
            cycles++;
        end
        host_rd_resp_valid = 1'b1;
        host_rd_resp_data  = d;
        tick();
        cycles++;
        host_rd_resp_valid = 1'b0;
        host_rd_resp_data  = '0;
        check(rd_done && !empty, "rd_done with empty low", DW'({rd_done, empty}), DW'(2'b10));
        rd_go = 1'b0;
        tick();
        check(!rd_done, "rd_done single cycle", DW'(rd_done), '0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int delay,
                           output int cycles);
        exp_ra.push_back(a);
        exp_rd.push_back(d);
        rd_go   = 1'b1;
        rd_addr = a;
        wait_issue(cycles);
        complete_read(d, delay, cycles);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!host_wr_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(ok && exp_wa.size() == 0, "write FIFO drained", DW'(exp_wa.size()), '0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit ok;
        rst = 1'b1;
        rd_go = 1'b0; rd_addr = '0;
        wr_go = 1'b0; wr_addr = '0; wr_data = '0;
        host_rd_req_ready = 1'b1;
        host_rd_resp_valid = 1'b0; host_rd_resp_data = '0;
        host_wr_req_ready = 1'b0;
        #1;
        check({rd_done, empty, wr_done, full, host_rd_req_valid, host_wr_req_valid} == '0,
              "reset control outputs", DW'({rd_done, empty, wr_done, full, host_rd_req_valid,
              host_wr_req_valid}), '0);
        check(rd_data == '0 && host_wr_req_data == '0, "reset data outputs", rd_data, '0);
        check(host_rd_req_addr == '0 && host_wr_req_addr == '0, "reset addr outputs",
              DW'(host_rd_req_addr), '0);
        tick();
        rst = 1'b0;
        tick();

        // Async reset mid-operation drops buffered writes
        do_write(36'h77, DW'(1));
        do_write(36'h78, DW'(2));
        check(host_wr_req_valid, "writes buffered before reset", DW'(host_wr_req_valid), DW'(1));
        #2 rst = 1'b1;
        #1;
        check(!host_wr_req_valid && !full && !wr_done && host_wr_req_addr == '0,
              "outputs zero immediately on async reset", DW'(host_wr_req_addr), '0);
        exp_wa.delete();
        exp_wd.delete();
        tick();
        rst = 1'b0;
        host_wr_req_ready = 1'b1;
        tick();
        tick();
        check(!host_wr_req_valid, "buffered writes dropped by reset", DW'(host_wr_req_valid), '0);
        host_wr_req_ready = 1'b0;

        // Fill, stall the ninth write, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check(!full, "not full at DEPTH-1", DW'(full), '0);
            do_write(AW'(36'h10 + i), DW'(32'hA000 + i));
        end
        check(full, "full after DEPTH writes", DW'(full), DW'(1));
        exp_wa.push_back(36'h18);
        exp_wd.push_back(DW'(32'hA008));
        wr_go = 1'b1; wr_addr = 36'h18; wr_data = DW'(32'hA008);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_done || !full) ok = 1'b0;
        end
        check(ok, "ninth write stalled while full", DW'(ok), DW'(1));
        host_wr_req_ready = 1'b1;
        tick();
        check(!full, "full drops after first pop", DW'(full), '0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wr_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        wr_go = 1'b0;
        check(ok, "ninth write accepted after pop", DW'(ok), DW'(1));
        drain();

        // Reads through the host: delayed response, then minimum latency
        do_read(36'h123, DW'(12'hABC), 5, lat);
        check(lat == 9, "read latency with 5-cycle resp", DW'(lat), DW'(9));
        do_read(36'h456, {16{32'hDEADBEEF}}, 0, lat);
        check(lat == 4, "minimum read latency", DW'(lat), DW'(4));

        // Read-after-write hazard holds the read until the write leaves
        host_wr_req_ready = 1'b0;
        do_write(36'h40, DW'(8'h55));
        exp_ra.push_back(36'h40);
        exp_rd.push_back(DW'(8'h77));
        rd_go = 1'b1; rd_addr = 36'h40;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (host_rd_req_valid || !empty) ok = 1'b0;
        end
        check(ok, "no host read while hazard buffered", DW'(ok), DW'(1));
        host_wr_req_ready = 1'b1;
        wait_issue(lat);
        check(exp_wa.size() == 0 && !host_wr_req_valid, "write drained before read issue",
              DW'(exp_wa.size()), '0);
        complete_read(DW'(8'h77), 1, lat);

        // Wrap: 3*DEPTH writes under random host ready with reads running alongside
        wr_phase_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH; i++)
                    do_write(AW'(36'h300 + i), {8{64'hC0DE_0000_0000_0000 | 64'(i)}});
                wr_phase_done = 1'b1;
            end
            begin
                int l;
                for (int j = 0; j < 3; j++)
                    do_read(AW'(36'h200 + j), DW'(32'hF00 + j), j, l);
            end
            begin
                while (!wr_phase_done) begin
                    tick();
                    host_wr_req_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        host_wr_req_ready = 1'b1;
        drain();

        repeat (3) tick();
        check(exp_ra.size() == 0 && exp_rd.size() == 0, "all reads consumed",
              DW'(exp_ra.size() + exp_rd.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
